// File: rtl/integration_pkg.sv
// Shared AHB encodings and helpers for the integration fabric.
// Pure declarations; no timing or flow control of its own.
package integration_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  localparam int BURST_CNT_W = 5;

  // Undefined-length INCR counts as a single beat: it is never protected.
  function automatic logic [BURST_CNT_W-1:0] burst_beats(hburst_t b);
    logic [BURST_CNT_W-1:0] beats;
    case (b)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Rotating-base priority picker: first request strictly after base wins.
// Purely combinational, zero latency; no backpressure.
module ahb_arb_picker
  import integration_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MASTER_W    = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MASTER_W-1:0]    base,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic                   vld
);

  int idx;

  // Scan base+1 .. base+NUM_MASTERS, wrapping; base = NUM_MASTERS-1 gives fixed priority.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = int'(base) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB arbiter: registered one-hot grant, burst/lock protection, RETRY/SPLIT masking.
// Request to grant 1 cycle in ARB; grant to hmaster 1 hready cycle; stalls while hready=0.
module ahb_bus_arbiter
  import integration_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int MASTER_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int ARB_MODE       = 0,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [NUM_MASTERS-1:0] hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MASTER_W-1:0]    hmaster,
  output logic                   hmastlock
);

  localparam logic [NUM_MASTERS-1:0] DEF_GNT    = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MASTER_W-1:0]    DEF_IDX    = MASTER_W'(DEFAULT_MASTER);
  localparam logic [MASTER_W-1:0]    FIXED_BASE = MASTER_W'(NUM_MASTERS - 1);
  localparam bit                     RR_MODE    = (ARB_MODE == int'(ARB_ROUND_ROBIN));

  arb_state_t               state, state_nxt;
  logic [BURST_CNT_W-1:0]   burst_rem, burst_rem_nxt;
  logic [NUM_MASTERS-1:0]   split_mask, split_mask_nxt, split_set;
  logic [MASTER_W-1:0]      rr_ptr;
  logic [MASTER_W-1:0]      gidx, win_idx, pick_base;
  logic [NUM_MASTERS-1:0]   req, pick_gnt, win_gnt;
  logic                     pick_vld;
  logic                     resp_abort, resp_first, lock_hold, burst_active, rearb;
  htrans_t                  trans;
  hresp_t                   resp;

  assign trans = htrans_t'(htrans);
  assign resp  = hresp_t'(hresp);

  // RETRY/SPLIT spans two cycles: hready=0 first, hready=1 second.
  assign resp_abort = (resp == HRESP_RETRY) || (resp == HRESP_SPLIT);
  assign resp_first = resp_abort && !hready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (hgrant[i]) gidx = MASTER_W'(i);
  end

  always_comb begin
    burst_rem_nxt = burst_rem;
    if (resp_first) begin
      burst_rem_nxt = '0;
    end else if (hready) begin
      case (trans)
        HTRANS_NONSEQ: burst_rem_nxt = burst_beats(hburst_t'(hburst)) - 5'd1;
        HTRANS_SEQ:    if (burst_rem != '0) burst_rem_nxt = burst_rem - 5'd1;
        default:       ;
      endcase
    end
  end

  // A SPLIT against the default master cannot park it, so it degrades to RETRY.
  always_comb begin
    split_set = '0;
    if (resp_first && resp == HRESP_SPLIT && hmaster != DEF_IDX)
      split_set[hmaster] = 1'b1;
  end

  assign split_mask_nxt = (split_mask & ~hsplit) | split_set;

  assign lock_hold    = hlock[gidx] && !split_mask[gidx];
  assign burst_active = (burst_rem_nxt != '0);

  always_comb begin
    state_nxt = ST_ARB;
    if (!resp_abort) begin
      case (state)
        ST_LOCKED: state_nxt = lock_hold ? ST_LOCKED : (burst_active ? ST_BURST : ST_ARB);
        default:   state_nxt = lock_hold ? ST_LOCKED : (burst_active ? ST_BURST : ST_ARB);
      endcase
    end
  end

  assign req       = hbusreq & ~split_mask;
  assign pick_base = RR_MODE ? rr_ptr : FIXED_BASE;

  ahb_arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MASTER_W    (MASTER_W)
  ) u_picker (
    .req  (req),
    .base (pick_base),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  assign win_gnt = pick_vld ? pick_gnt : DEF_GNT;
  assign rearb   = hready && (state_nxt == ST_ARB);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (win_gnt[i]) win_idx = MASTER_W'(i);
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state      <= ST_ARB;
      burst_rem  <= '0;
      split_mask <= '0;
      rr_ptr     <= DEF_IDX;
      hgrant     <= DEF_GNT;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_rem  <= burst_rem_nxt;
      split_mask <= split_mask_nxt;
      if (hready) begin
        hmaster   <= gidx;
        hmastlock <= hlock[gidx];
      end
      if (rearb && win_gnt != hgrant) begin
        hgrant <= win_gnt;
        rr_ptr <= win_idx;
      end
    end
  end

endmodule
